// File: rtl/pipe_stage_chain.sv
// Parametrised valid/ready register chain with per-stage kill and occupancy count.
// Optional PIPE_STAGE_SKID_EN adds a 1-entry skid register so that in_ready comes from a flop.
module pipe_stage_chain #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned STAGES = 4,
`ifdef PIPE_STAGE_SKID_EN
   parameter int unsigned CNT_W  = $clog2(STAGES + 2)
`else
   parameter int unsigned CNT_W  = $clog2(STAGES + 1)
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [STAGES-1:0] kill,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  occupancy
);

   logic [STAGES-1:0] valid_q, valid_d, ev;
   logic [DATA_W-1:0] data_q [STAGES];
   logic [DATA_W-1:0] data_d [STAGES];
   logic [STAGES:0]   rdy;
   logic              src0_valid;
   logic [DATA_W-1:0] src0_data;
   logic [CNT_W-1:0]  occ_q, occ_d;
   logic              skid_cnt;

   // A killed element is a bubble, so its stage counts as free in the same cycle.
   always_comb begin
      ev          = valid_q & ~kill;
      rdy[STAGES] = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         rdy[i] = ~ev[i] | rdy[i+1];
      end
   end

`ifdef PIPE_STAGE_SKID_EN
   logic              skid_q, skid_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;

   always_comb begin
      skid_d      = skid_q;
      skid_data_d = skid_data_q;
      src0_valid  = skid_q ? 1'b1 : in_valid;
      src0_data   = skid_q ? skid_data_q : in_data;
      if (skid_q) begin
         if (rdy[0]) skid_d = 1'b0;
      end else if (in_valid && !rdy[0]) begin
         skid_d      = 1'b1;
         skid_data_d = in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         skid_q      <= 1'b0;
         skid_data_q <= '0;
      end else begin
         skid_q      <= skid_d;
         skid_data_q <= skid_data_d;
      end
   end

   assign in_ready = ~skid_q;
   assign skid_cnt = skid_d;
`else
   assign src0_valid = in_valid;
   assign src0_data  = in_data;
   assign in_ready   = rdy[0];
   assign skid_cnt   = 1'b0;
`endif

   always_comb begin
      valid_d[0] = rdy[0] ? src0_valid : ev[0];
      data_d[0]  = rdy[0] ? src0_data : data_q[0];
      for (int i = 1; i < STAGES; i++) begin
         valid_d[i] = rdy[i] ? ev[i-1] : ev[i];
         data_d[i]  = rdy[i] ? data_q[i-1] : data_q[i];
      end
   end

   always_comb begin
      occ_d = CNT_W'(skid_cnt);
      for (int i = 0; i < STAGES; i++) begin
         occ_d = occ_d + CNT_W'(valid_d[i]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         occ_q   <= '0;
         for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         occ_q   <= occ_d;
         for (int i = 0; i < STAGES; i++) data_q[i] <= data_d[i];
      end
   end

   assign out_valid = ev[STAGES-1];
   assign out_data  = data_q[STAGES-1];
   assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain (default build, STAGES=4, DATA_W=32).
module tb_pipe_stage_chain;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STAGES = 4;
`ifdef PIPE_STAGE_SKID_EN
   localparam int unsigned CNT_W = $clog2(STAGES + 2);
`else
   localparam int unsigned CNT_W = $clog2(STAGES + 1);
`endif

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic [STAGES-1:0] kill;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic [CNT_W-1:0]  occupancy;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   pipe_stage_chain #(
      .DATA_W (DATA_W),
      .STAGES (STAGES)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .kill      (kill),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every output handshake must match the head of the expected queue.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got 0x%0h expected none", out_data);
         end else begin
            check("out_data", out_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      kill      = '0;
      out_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_occupancy", occupancy, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Streaming 1..8 with out_ready held high
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 1;
      for (int v = 1; v <= 8; v++) exp_q.push_back(v);
      #1 check("stream_in_ready", in_ready, 1);
      step();
      for (int k = 2; k <= 8; k++) begin
         in_data = k;
         #1;
         check("stream_in_ready", in_ready, 1);
         check("stream_occupancy", occupancy, (k - 1 > 4) ? 4 : k - 1);
         if (k <= 5) check("stream_latency", out_valid, (k >= 5) ? 1 : 0);
         step();
      end
      in_valid = 1'b0;
      repeat (5) step();
      check("stream_drained", occupancy, 0);

      // Back-pressure: fill A..D, stall, offer an extra element that must not enter
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int v = 'hA; v <= 'hD; v++) begin
         in_data = v;
         exp_q.push_back(v);
         step();
      end
      in_data = 'hEE;
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 'hA);
      check("bp_occupancy", occupancy, 4);
      step();
      step();
      check("bp_hold_data", out_data, 'hA);
      check("bp_hold_occupancy", occupancy, 4);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (5) step();
      check("bp_drained", occupancy, 0);

      // Bubble collapse behind a stalled element
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 'h55;
      exp_q.push_back('h55);
      step();
      in_valid = 1'b0;
      repeat (3) step();
      check("bub_occ1", occupancy, 1);
      check("bub_out_data", out_data, 'h55);
      in_valid = 1'b1;
      in_data  = 'h66;
      exp_q.push_back('h66);
      #1 check("bub_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      repeat (3) step();
      check("bub_occ2", occupancy, 2);
      check("bub_valid_map", dut.valid_q, 4'b1100);
      check("bub_in_ready2", in_ready, 1);
      out_ready = 1'b1;
      repeat (4) step();
      check("bub_drained", occupancy, 0);

      // Kill stage 2 while it holds element 5
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 1;
      exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4);
      exp_q.push_back(6); exp_q.push_back(7); exp_q.push_back(8);
      step();
      for (int k = 2; k <= 8; k++) begin
         in_data = k;
         if (k == 8) begin
            kill = 4'b0100;
            #1 check("kill_occ_before", occupancy, 4);
         end
         step();
         kill = '0;
      end
      in_valid = 1'b0;
      #1 check("kill_occ_after", occupancy, 3);
      repeat (5) step();
      check("kill_drained", occupancy, 0);

      // Kill the last stage of a stalled full chain, then kill during out_ready=1
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int v = 'h21; v <= 'h24; v++) begin
         in_data = v;
         step();
      end
      in_valid = 1'b0;
      exp_q.push_back('h23);
      exp_q.push_back('h24);
      #1;
      check("kst_occ_full", occupancy, 4);
      check("kst_in_ready_full", in_ready, 0);
      kill = 4'b1000;
      #1;
      check("kst_in_ready_kill", in_ready, 1);
      check("kst_out_valid_kill", out_valid, 0);
      step();
      kill = '0;
      #1;
      check("kst_occ_after", occupancy, 3);
      check("kst_out_data", out_data, 'h22);
      out_ready = 1'b1;
      kill      = 4'b1000;
      #1 check("khs_out_valid", out_valid, 0);
      step();
      kill = '0;
      #1 check("khs_occ", occupancy, 2);
      repeat (4) step();
      check("kst_drained", occupancy, 0);

      // Reset with three live elements, then a fresh element
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int v = 'h31; v <= 'h33; v++) begin
         in_data = v;
         step();
      end
      in_valid = 1'b0;
      #1 check("rmid_occ", occupancy, 3);
      reset = 1'b1;
      #1;
      check("rmid_out_valid", out_valid, 0);
      check("rmid_occ_async", occupancy, 0);
      step();
      reset     = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 'h77;
      exp_q.push_back('h77);
      step();
      in_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
         check("rmid_latency_empty", out_valid, 0);
         step();
      end
      check("rmid_latency_valid", out_valid, 1);
      check("rmid_latency_data", out_data, 'h77);
      repeat (2) step();

      check("sb_empty", exp_q.size(), 0);
      check("final_occ", occupancy, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
